// File: rtl/voice_scheduler.sv
// Voice scheduler: hands notes from the song reader to a bank of note_players,
// times each note (and each rest) in beats, and strobes load/done per voice.
module voice_scheduler #(
    parameter int NUM_VOICES = 3,
    parameter int DUR_WIDTH  = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play_enable,
    input  logic                      beat,
    input  logic                      note_valid,
    input  logic [5:0]                note_in,
    input  logic [DUR_WIDTH-1:0]      duration_in,
    output logic                      note_ready,
    output logic [NUM_VOICES-1:0]     load_new_note,
    output logic [6*NUM_VOICES-1:0]   note_to_load,
    output logic [NUM_VOICES-1:0]     note_done,
    output logic [NUM_VOICES-1:0]     voice_busy,
    output logic                      rest_active
);

    logic [NUM_VOICES-1:0][DUR_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_VOICES-1:0]                busy_q, busy_d;
    logic [NUM_VOICES-1:0]                load_q, load_d;
    logic [NUM_VOICES-1:0]                done_q, done_d;
    logic [6*NUM_VOICES-1:0]              note_q, note_d;
    logic [DUR_WIDTH-1:0]                 rest_cnt_q, rest_cnt_d;
    logic                                 rest_active_q, rest_active_d;

    logic [NUM_VOICES-1:0] free_mask;
    logic [NUM_VOICES-1:0] alloc_oh;
    logic [DUR_WIDTH-1:0]  dur_eff;
    logic                  is_rest;
    logic                  accept;
    logic                  tick;

    assign is_rest    = (note_in == 6'd0);
    assign free_mask  = ~busy_q;
    // Isolate the lowest free voice so allocation always prefers voice 0.
    assign alloc_oh   = free_mask & (~free_mask + NUM_VOICES'(1));
    assign dur_eff    = (duration_in == '0) ? DUR_WIDTH'(1) : duration_in;
    assign note_ready = play_enable & ~rest_active_q & (is_rest | (|free_mask));
    assign accept     = note_valid & note_ready;
    assign tick       = beat & play_enable;

    always_comb begin
        cnt_d         = cnt_q;
        busy_d        = busy_q;
        note_d        = note_q;
        load_d        = '0;
        done_d        = '0;
        rest_cnt_d    = rest_cnt_q;
        rest_active_d = rest_active_q;

        for (int v = 0; v < NUM_VOICES; v++) begin
            if (accept && !is_rest && alloc_oh[v]) begin
                cnt_d[v]         = dur_eff;
                busy_d[v]        = 1'b1;
                load_d[v]        = 1'b1;
                note_d[6*v +: 6] = note_in;
            end else if (tick && busy_q[v]) begin
                cnt_d[v] = cnt_q[v] - DUR_WIDTH'(1);
                if (cnt_q[v] == DUR_WIDTH'(1)) begin
                    busy_d[v] = 1'b0;
                    done_d[v] = 1'b1;
                end
            end
        end

        // A rest can only be accepted while no rest is running, so load and
        // countdown never collide here.
        if (accept && is_rest) begin
            rest_cnt_d    = dur_eff;
            rest_active_d = 1'b1;
        end else if (tick && rest_active_q) begin
            rest_cnt_d = rest_cnt_q - DUR_WIDTH'(1);
            if (rest_cnt_q == DUR_WIDTH'(1)) begin
                rest_active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            busy_q        <= '0;
            load_q        <= '0;
            done_q        <= '0;
            note_q        <= '0;
            rest_cnt_q    <= '0;
            rest_active_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            load_q        <= load_d;
            done_q        <= done_d;
            note_q        <= note_d;
            rest_cnt_q    <= rest_cnt_d;
            rest_active_q <= rest_active_d;
        end
    end

    assign load_new_note = load_q;
    assign note_done     = done_q;
    assign voice_busy    = busy_q;
    assign note_to_load  = note_q;
    assign rest_active   = rest_active_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: allocation, rests, pause, same-edge
// accept/beat, zero duration and asynchronous reset.
module tb_voice_scheduler;

   logic        clock;
   logic        reset;
   logic        playEnable;
   logic        beat;
   logic        noteValid;
   logic [5:0]  noteIn;
   logic [5:0]  durationIn;
   logic        noteReady;
   logic [2:0]  loadNewNote;
   logic [17:0] noteToLoad;
   logic [2:0]  noteDone;
   logic [2:0]  voiceBusy;
   logic        restActive;

   int vectorCount = 0;
   int missCount   = 0;

   voice_scheduler #(.NUM_VOICES(3), .DUR_WIDTH(6)) dut (
      .clk          (clock),
      .reset        (reset),
      .play_enable  (playEnable),
      .beat         (beat),
      .note_valid   (noteValid),
      .note_in      (noteIn),
      .duration_in  (durationIn),
      .note_ready   (noteReady),
      .load_new_note(loadNewNote),
      .note_to_load (noteToLoad),
      .note_done    (noteDone),
      .voice_busy   (voiceBusy),
      .rest_active  (restActive)
   );

   // Free-running clock, 10 time units per period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One comparison: count it, and report it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one clock edge and settle just after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One-cycle beat pulse across the next edge.
   task automatic pulseBeat();
      beat = 1'b1;
      step();
      beat = 1'b0;
   endtask

   // Present a note; caller decides how long noteValid stays high.
   task automatic applyStimulus(input logic [5:0] note, input logic [5:0] dur);
      noteValid  = 1'b1;
      noteIn     = note;
      durationIn = dur;
      #1;
   endtask

   initial begin
      reset      = 1'b0;
      playEnable = 1'b0;
      beat       = 1'b0;
      noteValid  = 1'b0;
      noteIn     = 6'd0;
      durationIn = 6'd0;
      step();
      step();
      checkOutput("reset_busy", 32'(voiceBusy), 0);
      checkOutput("reset_load", 32'(loadNewNote), 0);
      checkOutput("reset_done", 32'(noteDone), 0);
      checkOutput("reset_rest", 32'(restActive), 0);
      checkOutput("reset_notes", 32'(noteToLoad), 0);
      reset      = 1'b1;
      playEnable = 1'b1;
      step();

      // Single note, two beats long.
      applyStimulus(6'd45, 6'd2);
      checkOutput("t1_ready", 32'(noteReady), 1);
      step();
      noteValid = 1'b0;
      checkOutput("t1_load", 32'(loadNewNote), 1);
      checkOutput("t1_note", 32'(noteToLoad[5:0]), 45);
      checkOutput("t1_busy", 32'(voiceBusy), 1);
      step();
      checkOutput("t1_load_clr", 32'(loadNewNote), 0);
      pulseBeat();
      checkOutput("t1_done_early", 32'(noteDone), 0);
      checkOutput("t1_busy_mid", 32'(voiceBusy), 1);
      pulseBeat();
      checkOutput("t1_done", 32'(noteDone), 1);
      checkOutput("t1_busy_end", 32'(voiceBusy), 0);
      step();
      checkOutput("t1_done_clr", 32'(noteDone), 0);

      // Fill all three voices, then stall a fourth note until they finish.
      applyStimulus(6'd45, 6'd4);
      step();
      checkOutput("t2_load0", 32'(loadNewNote), 1);
      applyStimulus(6'd32, 6'd4);
      step();
      checkOutput("t2_load1", 32'(loadNewNote), 2);
      applyStimulus(6'd20, 6'd4);
      step();
      checkOutput("t2_load2", 32'(loadNewNote), 4);
      checkOutput("t2_busy", 32'(voiceBusy), 7);
      applyStimulus(6'd12, 6'd4);
      checkOutput("t2_full_ready", 32'(noteReady), 0);
      for (int i = 0; i < 3; i++) begin
         pulseBeat();
         checkOutput("t2_stall_ready", 32'(noteReady), 0);
         checkOutput("t2_stall_load", 32'(loadNewNote), 0);
      end
      pulseBeat();
      checkOutput("t2_done_all", 32'(noteDone), 7);
      checkOutput("t2_busy_clr", 32'(voiceBusy), 0);
      checkOutput("t2_no_early_load", 32'(loadNewNote), 0);
      checkOutput("t2_ready_after", 32'(noteReady), 1);
      step();
      noteValid = 1'b0;
      checkOutput("t2_load_fourth", 32'(loadNewNote), 1);
      checkOutput("t2_note_fourth", 32'(noteToLoad[5:0]), 12);
      checkOutput("t2_v1_held", 32'(noteToLoad[11:6]), 32);
      checkOutput("t2_v2_held", 32'(noteToLoad[17:12]), 20);
      for (int i = 0; i < 4; i++) pulseBeat();
      checkOutput("t2_fourth_done", 32'(noteDone), 1);
      step();

      // Rest of three beats blocks the next note.
      applyStimulus(6'd0, 6'd3);
      checkOutput("t3_ready", 32'(noteReady), 1);
      step();
      checkOutput("t3_rest_on", 32'(restActive), 1);
      checkOutput("t3_no_load", 32'(loadNewNote), 0);
      checkOutput("t3_no_busy", 32'(voiceBusy), 0);
      applyStimulus(6'd32, 6'd1);
      checkOutput("t3_blocked", 32'(noteReady), 0);
      for (int i = 0; i < 2; i++) begin
         pulseBeat();
         checkOutput("t3_rest_hold", 32'(restActive), 1);
         checkOutput("t3_blocked_beat", 32'(noteReady), 0);
      end
      pulseBeat();
      checkOutput("t3_rest_off", 32'(restActive), 0);
      checkOutput("t3_ready_again", 32'(noteReady), 1);
      checkOutput("t3_load_wait", 32'(loadNewNote), 0);
      step();
      noteValid = 1'b0;
      checkOutput("t3_load", 32'(loadNewNote), 1);
      checkOutput("t3_note", 32'(noteToLoad[5:0]), 32);
      pulseBeat();
      checkOutput("t3_done", 32'(noteDone), 1);
      step();

      // Pause: two beats, five frozen beats, then two more.
      applyStimulus(6'd45, 6'd4);
      step();
      noteValid = 1'b0;
      pulseBeat();
      pulseBeat();
      playEnable = 1'b0;
      applyStimulus(6'd20, 6'd2);
      checkOutput("t4_pause_ready", 32'(noteReady), 0);
      for (int i = 0; i < 5; i++) begin
         pulseBeat();
         checkOutput("t4_pause_busy", 32'(voiceBusy), 1);
         checkOutput("t4_pause_done", 32'(noteDone), 0);
         checkOutput("t4_pause_load", 32'(loadNewNote), 0);
         checkOutput("t4_pause_ready_b", 32'(noteReady), 0);
      end
      noteValid  = 1'b0;
      playEnable = 1'b1;
      pulseBeat();
      checkOutput("t4_resume_one", 32'(noteDone), 0);
      checkOutput("t4_resume_busy", 32'(voiceBusy), 1);
      pulseBeat();
      checkOutput("t4_done", 32'(noteDone), 1);
      step();

      // Accept on a beat edge with durations 1 and 0.
      for (int k = 0; k < 2; k++) begin
         applyStimulus(6'd20, (k == 0) ? 6'd1 : 6'd0);
         beat = 1'b1;
         step();
         beat      = 1'b0;
         noteValid = 1'b0;
         checkOutput("t5_load", 32'(loadNewNote), 1);
         checkOutput("t5_busy", 32'(voiceBusy), 1);
         checkOutput("t5_no_done", 32'(noteDone), 0);
         step();
         checkOutput("t5_still_busy", 32'(voiceBusy), 1);
         pulseBeat();
         checkOutput("t5_done", 32'(noteDone), 1);
         checkOutput("t5_free", 32'(voiceBusy), 0);
         step();
      end

      // Asynchronous reset with two voices busy.
      applyStimulus(6'd45, 6'd5);
      step();
      applyStimulus(6'd32, 6'd5);
      step();
      noteValid = 1'b0;
      checkOutput("t6_busy_pre", 32'(voiceBusy), 3);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("t6_async_busy", 32'(voiceBusy), 0);
      checkOutput("t6_async_load", 32'(loadNewNote), 0);
      checkOutput("t6_async_notes", 32'(noteToLoad), 0);
      checkOutput("t6_async_rest", 32'(restActive), 0);
      step();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pulseBeat();
         checkOutput("t6_no_done", 32'(noteDone), 0);
      end
      applyStimulus(6'd12, 6'd2);
      step();
      noteValid = 1'b0;
      checkOutput("t6_load_v0", 32'(loadNewNote), 1);
      checkOutput("t6_note_v0", 32'(noteToLoad[5:0]), 12);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
